// File: rtl/reg_share_arb.sv
// Round-robin sharing of one W-bit capture register among four requesters.
// Grant, load, then a one-cycle acknowledge; one capture per three cycles at most.
module reg_share_arb #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] data_in,
    output logic [3:0]     grant,
    output logic [3:0]     ack,
    output logic [W-1:0]   reg_out,
    output logic [1:0]     owner,
    output logic           valid
);

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [IW-1:0]   win, win_nxt;
    logic [IW-1:0]   pick, idx;
    logic [N-1:0]    grant_nxt, ack_nxt;
    logic [W-1:0]    reg_nxt;
    logic [IW-1:0]   owner_nxt;
    logic            valid_nxt;
    logic [W-1:0]    words [N];

    // Unpack the flat requester bus into per-requester words
    always_comb begin
        for (int i = 0; i < N; i++) begin
            words[i] = data_in[i*W +: W];
        end
    end

    // Rotating search from last+1; lower offsets overwrite higher ones so the nearest wins
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = N; i >= 1; i--) begin
            idx = last + IW'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        win_nxt   = win;
        grant_nxt = grant;
        ack_nxt   = '0;
        reg_nxt   = reg_out;
        owner_nxt = owner;
        valid_nxt = valid;
        unique case (state)
            IDLE: begin
                if (req != '0) begin
                    win_nxt   = pick;
                    grant_nxt = N'(1) << pick;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                reg_nxt   = words[win];
                owner_nxt = win;
                valid_nxt = 1'b1;
                ack_nxt   = N'(1) << win;
                state_nxt = ACK;
            end
            ACK: begin
                grant_nxt = '0;
                last_nxt  = win;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= IW'(3);
            win     <= '0;
            grant   <= '0;
            ack     <= '0;
            reg_out <= '0;
            owner   <= '0;
            valid   <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            win     <= win_nxt;
            grant   <= grant_nxt;
            ack     <= ack_nxt;
            reg_out <= reg_nxt;
            owner   <= owner_nxt;
            valid   <= valid_nxt;
        end
    end

endmodule
